// File: rtl/text_write_ctrl_pkg.sv
// Shared constants, state encoding and row arithmetic for the 80x30 text buffer
// write path. The renderer pulls COLS/ROWS from here as well.
package text_pkg;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int N      = COLS * ROWS;
  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_BS   = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic {IDLE, CLEAR} state_t;

  // First cell of the row holding addr; exact for every addr in 0..N.
  function automatic logic [ADDR_W-1:0] row_start(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] row;
    row = addr / COLS_A;
    return row * COLS_A;
  endfunction
endpackage

// File: rtl/text_write_ctrl_if.sv
// Character source handshake bundle: source A (UART) and source B (keyboard).
// Handshake: a char moves when valid and ready are both high in the same cycle;
// ready is combinational from valid, never the other way round.
interface text_write_ctrl_if;
  logic       a_valid;
  logic [7:0] a_char;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_char;
  logic       b_ready;

  modport master (output a_valid, a_char, b_valid, b_char, input a_ready, b_ready);
  modport slave  (input a_valid, a_char, b_valid, b_char, output a_ready, b_ready);
endinterface

// File: rtl/text_write_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester not served last wins;
// after reset requester 1 counts as last served so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_b;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_b <= 1'b1;
    else if (accept) last_b <= gnt[1];
  end
endmodule

// File: rtl/text_write_ctrl.sv
// Owns the character buffer write port: arbitrates two char sources, tracks the
// cursor, interprets CR/LF/BS and sweeps the page blank on overflow or request.
module text_write_ctrl
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  text_write_ctrl_if.slave  src,
  input  logic              clr_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output state_t            state
);
  state_t            state_n;
  logic [1:0]        req, gnt;
  logic              accept;
  logic [7:0]        ch;
  logic [ADDR_W-1:0] cursor_n, cnt, cnt_n, wr_addr_n, rs, lf_next;
  logic [7:0]        wr_data_n;
  logic              wr_en_n;

  // Requests are masked in reset, during the sweep and when a clear wins the cycle.
  assign req = {src.b_valid, src.a_valid} & {2{reset_n && state == IDLE && !clr_req}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .accept  (accept),
    .gnt     (gnt)
  );

  assign accept      = |gnt;
  assign src.a_ready = gnt[0];
  assign src.b_ready = gnt[1];
  assign ch          = gnt[1] ? src.b_char : src.a_char;
  assign rs          = row_start(cursor);
  assign lf_next     = rs + COLS_A;
  assign busy        = (state == CLEAR);

  always_comb begin
    state_n   = state;
    cursor_n  = cursor;
    cnt_n     = cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (clr_req) begin
          state_n = CLEAR;
        end else if (accept) begin
          if (ch >= PRINT_LO && ch <= PRINT_HI) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cursor;
            wr_data_n = ch;
            cursor_n  = cursor + ADDR_W'(1);
            if (cursor_n == N_A) state_n = CLEAR;
          end else if (ch == CHR_CR) begin
            cursor_n = rs;
          end else if (ch == CHR_LF) begin
            cursor_n = lf_next;
            if (lf_next == N_A) state_n = CLEAR;
          end else if (ch == CHR_BS && cursor != '0) begin
            cursor_n  = cursor - ADDR_W'(1);
            wr_en_n   = 1'b1;
            wr_addr_n = cursor - ADDR_W'(1);
            wr_data_n = BLANK;
          end
        end
      end
      CLEAR: begin
        // One extra cycle after the last blank keeps busy aligned with the final write.
        if (cnt == N_A) begin
          state_n  = IDLE;
          cursor_n = '0;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = cnt;
          wr_data_n = BLANK;
          cnt_n     = cnt + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cursor  <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cursor  <= cursor_n;
      cnt     <= cnt_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end
endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl: inputs change on the falling edge, outputs
// are sampled on the falling edge (registered) or 1ns after it (ready).
module tb_text_write_ctrl;
  import text_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clr_req = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] cursor;
  logic              busy;
  state_t            state;
  int                pass_cnt = 0;
  int                total_cnt = 0;

  text_write_ctrl_if src();

  text_write_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .src     (src),
    .clr_req (clr_req),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cursor  (cursor),
    .busy    (busy),
    .state   (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    src.a_valid = 1'b0;
    src.a_char  = 8'h00;
    src.b_valid = 1'b0;
    src.b_char  = 8'h00;
    clr_req     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] c);
    src.a_char  = c;
    src.a_valid = 1'b1;
    @(negedge clk);
    src.a_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    src.a_valid = 1'b1;
    src.a_char  = 8'h41;
    #1;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor, busy, src.a_ready, state} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h cur=%0d busy=%b ardy=%b st=%0d, want all 0",
               wr_en, wr_addr, wr_data, cursor, busy, src.a_ready, state);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({src.a_ready, wr_en, busy} !== 3'b000)
      $display("FAIL reset_hold: got ardy=%b en=%b busy=%b, want 000", src.a_ready, wr_en, busy);
    else pass_cnt++;
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_hi();
    do_reset();
    src.a_char  = 8'h48;
    src.a_valid = 1'b1;
    #1;
    total_cnt++;
    if (src.a_ready !== 1'b1) $display("FAIL hi_ready0: got %b want 1", src.a_ready);
    else pass_cnt++;
    @(negedge clk);
    src.a_char = 8'h69;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd0, 8'h48})
      $display("FAIL hi_write0: got en=%b addr=%0d data=%h want 1/0/48", wr_en, wr_addr, wr_data);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (src.a_ready !== 1'b1) $display("FAIL hi_ready1: got %b want 1", src.a_ready);
    else pass_cnt++;
    @(negedge clk);
    src.a_valid = 1'b0;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 12'd1, 8'h69, 12'd2})
      $display("FAIL hi_write1: got en=%b addr=%0d data=%h cur=%0d want 1/1/69/2",
               wr_en, wr_addr, wr_data, cursor);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wr_en !== 1'b0) $display("FAIL hi_idle: got wr_en=%b want 0", wr_en);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ch;
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        src.a_valid = 1'b1; src.a_char = 8'h61;
        src.b_valid = 1'b1; src.b_char = 8'h62;
      end else begin
        idle_inputs();
      end
      if (i > 0) begin
        exp_ch = ((i - 1) % 2 == 0) ? 8'h61 : 8'h62;
        total_cnt++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, ADDR_W'(i - 1), exp_ch})
          $display("FAIL rr_write%0d: got en=%b addr=%0d data=%h want 1/%0d/%h",
                   i - 1, wr_en, wr_addr, wr_data, i - 1, exp_ch);
        else pass_cnt++;
      end
      if (i < 4) begin
        #1;
        total_cnt++;
        if ({src.b_ready, src.a_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
          $display("FAIL rr_grant%0d: got b/a ready=%b%b want %s",
                   i, src.b_ready, src.a_ready, (i % 2 == 0) ? "01" : "10");
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ctrl_chars();
    do_reset();
    send_a(CHR_BS);
    total_cnt++;
    if ({wr_en, cursor} !== {1'b0, 12'd0})
      $display("FAIL bs_at_zero: got en=%b cur=%0d want 0/0", wr_en, cursor);
    else pass_cnt++;
    send_a(CHR_LF);
    repeat (5) send_a(8'h78);
    total_cnt++;
    if (cursor !== 12'd85) $display("FAIL cursor_85: got %0d want 85", cursor);
    else pass_cnt++;
    send_a(CHR_LF);
    total_cnt++;
    if ({wr_en, cursor} !== {1'b0, 12'd160})
      $display("FAIL lf: got en=%b cur=%0d want 0/160", wr_en, cursor);
    else pass_cnt++;
    repeat (3) send_a(8'h78);
    send_a(CHR_CR);
    total_cnt++;
    if ({wr_en, cursor} !== {1'b0, 12'd160})
      $display("FAIL cr: got en=%b cur=%0d want 0/160", wr_en, cursor);
    else pass_cnt++;
    send_a(CHR_BS);
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 12'd159, 8'h20, 12'd159})
      $display("FAIL bs: got en=%b addr=%0d data=%h cur=%0d want 1/159/20/159",
               wr_en, wr_addr, wr_data, cursor);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int                bad;
    logic [ADDR_W-1:0] bad_k, bad_addr;
    logic [7:0]        bad_data;
    logic [2:0]        bad_flags;
    do_reset();
    repeat (29) send_a(CHR_LF);
    repeat (79) send_a(8'h2E);
    total_cnt++;
    if (cursor !== 12'd2399) $display("FAIL cursor_2399: got %0d want 2399", cursor);
    else pass_cnt++;
    src.a_char  = 8'h5A;
    src.a_valid = 1'b1;
    @(negedge clk);
    src.a_char = 8'h51;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 12'd2399, 8'h5A, 1'b1})
      $display("FAIL ovf_last: got en=%b addr=%0d data=%h busy=%b want 1/2399/5A/1",
               wr_en, wr_addr, wr_data, busy);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (src.a_ready !== 1'b0) $display("FAIL ovf_ready: got %b want 0", src.a_ready);
    else pass_cnt++;
    bad = 0;
    bad_k = '0; bad_addr = '0; bad_data = '0; bad_flags = '0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      #1;
      if ({wr_en, wr_addr, wr_data, busy, src.a_ready} !== {1'b1, ADDR_W'(k), 8'h20, 1'b1, 1'b0}) begin
        if (bad == 0) begin
          bad_k = ADDR_W'(k); bad_addr = wr_addr; bad_data = wr_data;
          bad_flags = {wr_en, busy, src.a_ready};
        end
        bad++;
      end
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL ovf_sweep: %0d bad cycles, first at %0d got addr=%0d data=%h en/busy/ardy=%b want %0d/20/110",
               bad, bad_k, bad_addr, bad_data, bad_flags, bad_k);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({busy, src.a_ready, wr_en, cursor} !== {1'b0, 1'b1, 1'b0, 12'd0})
      $display("FAIL ovf_done: got busy=%b ardy=%b en=%b cur=%0d want 0/1/0/0",
               busy, src.a_ready, wr_en, cursor);
    else pass_cnt++;
    @(negedge clk);
    src.a_valid = 1'b0;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 12'd0, 8'h51, 12'd1})
      $display("FAIL ovf_next: got en=%b addr=%0d data=%h cur=%0d want 1/0/51/1",
               wr_en, wr_addr, wr_data, cursor);
    else pass_cnt++;
  endtask

  task automatic test_clr_reset();
    int n;
    do_reset();
    clr_req     = 1'b1;
    src.a_valid = 1'b1;
    src.a_char  = 8'h41;
    #1;
    total_cnt++;
    if ({src.b_ready, src.a_ready} !== 2'b00)
      $display("FAIL clr_ready: got b/a=%b%b want 00", src.b_ready, src.a_ready);
    else pass_cnt++;
    @(negedge clk);
    clr_req = 1'b0;
    total_cnt++;
    if ({busy, wr_en} !== 2'b10) $display("FAIL clr_start: got busy=%b en=%b want 1/0", busy, wr_en);
    else pass_cnt++;
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === 12'd1000) && n < 1100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n != 1001) $display("FAIL clr_reach1000: got %0d cycles want 1001", n);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor, busy, src.a_ready, state} !== '0)
      $display("FAIL mid_reset: got en=%b addr=%0d data=%h cur=%0d busy=%b ardy=%b st=%0d want all 0",
               wr_en, wr_addr, wr_data, cursor, busy, src.a_ready, state);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total_cnt++;
    if (src.a_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", src.a_ready);
    else pass_cnt++;
    @(negedge clk);
    src.a_valid = 1'b0;
    total_cnt++;
    if ({wr_en, wr_addr, wr_data, cursor} !== {1'b1, 12'd0, 8'h41, 12'd1})
      $display("FAIL post_reset_write: got en=%b addr=%0d data=%h cur=%0d want 1/0/41/1",
               wr_en, wr_addr, wr_data, cursor);
    else pass_cnt++;
  endtask

  task automatic test_other_codes();
    logic [7:0] codes [3];
    codes = '{8'h00, 8'h7F, 8'hFF};
    do_reset();
    repeat (3) send_a(8'h78);
    for (int i = 0; i < 3; i++) begin
      src.a_char  = codes[i];
      src.a_valid = 1'b1;
      #1;
      total_cnt++;
      if (src.a_ready !== 1'b1) $display("FAIL code_%h_ready: got %b want 1", codes[i], src.a_ready);
      else pass_cnt++;
      @(negedge clk);
      src.a_valid = 1'b0;
      total_cnt++;
      if ({wr_en, cursor} !== {1'b0, 12'd3})
        $display("FAIL code_%h_drop: got en=%b cur=%0d want 0/3", codes[i], wr_en, cursor);
      else pass_cnt++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_hi();
    test_back_to_back();
    test_ctrl_chars();
    test_overflow();
    test_clr_reset();
    test_other_codes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Sequencing controller that owns the write port of the 80x30 character buffer feeding the VGA text renderer. Two independent character sources (UART receiver and keyboard decoder) are arbitrated round-robin over a valid/ready handshake. The controller also maintains the cursor, interprets CR/LF/backspace, and runs a one-cell-per-cycle blanking sweep on page overflow or explicit request. The renderer only reads the buffer; all writes come from this block.

## Interface
- COLS, 80: characters per row
- ROWS, 30: rows per page
- ADDR_W, 12: buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- BLANK, 8'h20: code written by clear and backspace

- clk  in  1  system clock; one clock domain; reset is asynchronous and active-low
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  source A (UART) has a character
- a_char  in  8  source A character
- a_ready  out  1  source A character accepted this cycle when a_valid also high
- b_valid, b_char, b_ready  same as A for source B (keyboard)
- clr_req  in  1  single-cycle request to blank the page and home the cursor
- wr_en  out  1  buffer write strobe, registered
- wr_addr  out  ADDR_W  buffer write address, registered
- wr_data  out  8  buffer write data, registered
- cursor  out  ADDR_W  next cell to be written
- busy  out  1  high while the clear sweep runs

## Operation
- N = COLS*ROWS (2400). States: IDLE, CLEAR.
- IDLE, clr_req low: grant to the single valid source; if both valid, grant the source not served last. Only the granted source's ready is high (combinational from valid, state, clr_req, pointer). Accept = valid & ready. The pointer updates only on accept. At reset, B counts as last served, so A wins the first tie.
- Accepted char handling:
  - 0x20-0x7E: write char at cursor; cursor+1. If the new cursor equals N, go to CLEAR.
  - 0x0D (CR): cursor = (cursor/COLS)*COLS. No write.
  - 0x0A (LF): cursor = (cursor/COLS+1)*COLS. If that equals N, go to CLEAR. No write.
  - 0x08 (BS): if cursor != 0, cursor-1 and write BLANK at cursor-1. At cursor 0, no effect.
  - Any other code: accepted and dropped. No write, cursor unchanged.
- IDLE with clr_req high: go to CLEAR. clr_req wins over a simultaneous valid; both readies stay low that cycle.
- CLEAR: an internal counter runs 0..N-1 and writes BLANK at each address, one per cycle. Both readies are low and clr_req is ignored. After address N-1, cursor = 0 and the state returns to IDLE.
- Cursor arithmetic uses ADDR_W bits. Division by COLS may be a compare/subtract or constant-divide, but must be exact for all 0..N-1.
- The buffer is not cleared by reset. Reset mid-sweep abandons it; cells already blanked stay blank.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, cursor 0, busy 0, state IDLE, a_ready/b_ready 0 while reset_n low.
- Accept in cycle t: wr_en/wr_addr/wr_data are valid in t+1. cursor updates at the end of t.
- Throughput: one character per cycle with no bubbles in IDLE.
- Overflow accept in cycle t: the final character is written at t+1. Clear writes addresses 0..N-1 on cycles t+2..t+N+1. busy and ready-low hold from t+1 through t+N+1. Ready is available again at t+N+2.
- clr_req in cycle t (IDLE): clear writes on t+2..t+N+1 with the same busy window.
- wr_en is never high for two different sources in the same cycle. At most one write per cycle.

## Structure
- Package text_pkg holds COLS, ROWS, N, ADDR_W, BLANK, CHR_CR/CHR_LF/CHR_BS, the printable range bounds, and the state enum (IDLE, CLEAR). The renderer shares COLS/ROWS from the same package.
- One sub-module: rr_arb2, a 2-requester round-robin arbiter with req[1:0], accept, gnt[1:0] and a last-served register with async active-low reset.

## Test plan
- After reset, A sends "Hi" on back-to-back cycles: writes (0,0x48) then (1,0x69) on consecutive cycles; cursor=2.
- A and B valid every cycle with chars 'a'/'b': accepts alternate A,B,A,B; writes to addresses 0,1,2,3 carry a,b,a,b.
- Cursor 85, LF: cursor=160, no wr_en. Then CR at cursor 163: cursor=160. BS at 160: write (159,0x20), cursor=159.
- Cursor 2399, char 'Z': write (2399,0x5A), then 2400 BLANK writes for addresses 0..2399 with busy high and readies low. Cursor ends at 0.
- clr_req together with a_valid in IDLE: a_ready stays 0 and the sweep starts. Deassert reset_n at sweep address 1000: all outputs go to 0 immediately. After release, the next A char writes at address 0.
- Codes 0x00, 0x7F, 0xFF: accepted (ready pulses), no wr_en, cursor unchanged.
